// File: rtl/mac_pipe_acc.sv
// mac_pipe_acc: two-stage pipelined signed multiply-accumulate for the TABLA PE ALU.
// Stage 1 registers the full-width product and control. Stage 2 adds the product
// to either the sign-extended pre_result or the current output, then wraps or
// saturates into the guarded OUT_LEN-bit result.
module mac_pipe_acc #(
   parameter int LEN     = 8,
   parameter int OUT_LEN = 2*LEN+4,
   parameter int SAT     = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic               mode,
   input  logic               first,
   input  logic               last,
   input  logic [LEN-1:0]     in1,
   input  logic [LEN-1:0]     in2,
   input  logic [LEN-1:0]     pre_result,
   output logic [OUT_LEN-1:0] out,
   output logic               out_valid,
   output logic               overflow,
   output logic               ovf_sticky,
   output logic               done
);

   localparam logic [OUT_LEN-1:0] SAT_MAX = {1'b0, {(OUT_LEN-1){1'b1}}};
   localparam logic [OUT_LEN-1:0] SAT_MIN = {1'b1, {(OUT_LEN-1){1'b0}}};

   // Stage 1 state
   logic                 s1_valid_q;
   logic [2*LEN-1:0]     s1_prod_q, s1_prod_d;
   logic [OUT_LEN-1:0]   s1_pre_q, s1_pre_d;
   logic                 s1_mode_q, s1_first_q, s1_last_q;

   // Stage 2 / output state
   logic [OUT_LEN-1:0]   out_q, out_d;
   logic                 out_valid_q;
   logic                 overflow_q, overflow_d;
   logic                 ovf_sticky_q, ovf_sticky_d;
   logic                 done_q, done_d;

   // Stage 2 intermediates
   logic                 fresh;
   logic [OUT_LEN-1:0]   base;
   logic [OUT_LEN:0]     sum;

   // Stage 1 combinational: signed product formed from sign-extended operands
   // (low 2*LEN bits of the unsigned product are the exact signed product).
   always_comb begin
      s1_prod_d = {{LEN{in1[LEN-1]}}, in1} * {{LEN{in2[LEN-1]}}, in2};
      s1_pre_d  = {{(OUT_LEN-LEN){pre_result[LEN-1]}}, pre_result};
   end

   // Stage 1 registers; control is only captured with a valid operand.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_prod_q  <= '0;
         s1_pre_q   <= '0;
         s1_mode_q  <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
      end else begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_prod_q  <= s1_prod_d;
            s1_pre_q   <= s1_pre_d;
            s1_mode_q  <= mode;
            s1_first_q <= first;
            s1_last_q  <= last;
         end
      end
   end

   // Stage 2 combinational: choose base, add with one guard bit, wrap or clamp.
   // The clamped value is written to out and is what the next op accumulates on.
   always_comb begin
      fresh      = ~s1_mode_q | s1_first_q;
      base       = fresh ? s1_pre_q : out_q;
      sum        = {{(OUT_LEN+1-2*LEN){s1_prod_q[2*LEN-1]}}, s1_prod_q}
                 + {base[OUT_LEN-1], base};
      overflow_d = sum[OUT_LEN] ^ sum[OUT_LEN-1];
      if ((SAT != 0) && overflow_d)
         out_d = sum[OUT_LEN] ? SAT_MIN : SAT_MAX;
      else
         out_d = sum[OUT_LEN-1:0];
      ovf_sticky_d = overflow_d | (~fresh & ovf_sticky_q);
      done_d       = s1_valid_q & (~s1_mode_q | s1_last_q);
   end

   // Output registers; result and flags hold when no op leaves stage 2.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         overflow_q   <= 1'b0;
         ovf_sticky_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         out_valid_q <= s1_valid_q;
         done_q      <= done_d;
         if (s1_valid_q) begin
            out_q        <= out_d;
            overflow_q   <= overflow_d;
            ovf_sticky_q <= ovf_sticky_d;
         end
      end
   end

   assign out        = out_q;
   assign out_valid  = out_valid_q;
   assign overflow   = overflow_q;
   assign ovf_sticky = ovf_sticky_q;
   assign done       = done_q;

endmodule
